fetch_unit: RTL and testbench

Program-counter and fetch-control stage sitting directly upstream of instruction_memory in the RISC-V datapath. Generates the word index driven into the memory's readAddress and tracks the PC of the instruction the memory presents one cycle later. Handles stall replay, zero-bubble branch/jump redirect and end-of-program halt. instruction_memory has one-cycle registered latency and no read enable, and this block is built around that.

---
 rtl/riscv_fetch_pkg.sv | 23 ++
 rtl/fetch_addr_sel.sv | 43 ++++
 rtl/fetch_unit.sv | 73 +++++++
 tb/tb_fetch_unit.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/riscv_fetch_pkg.sv
// Shared fetch-stage types and helpers: FSM encoding, next-state select codes, byte-to-word index.
package riscv_fetch_pkg;

    localparam int unsigned INSTR_BYTES      = 4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic {
        FETCH_RUN  = 1'b0,
        FETCH_HALT = 1'b1
    } fetch_state_e;

    // How the registers advance on the next edge (reset handled separately).
    typedef enum logic [1:0] {
        SEL_SEQ    = 2'd0,
        SEL_BRANCH = 2'd1,
        SEL_HOLD   = 2'd2
    } fetch_sel_e;

    function automatic logic [31:0] word_idx(input logic [31:0] byte_addr);
        return byte_addr >> 2;
    endfunction

endpackage

// File: rtl/fetch_addr_sel.sv
// Combinational priority mux: memory read index, next-state select, issued address and its range check.
// Zero latency; a stall re-presents the current word since instruction memory has no enable.
module fetch_addr_sel
    import riscv_fetch_pkg::*;
#(
    parameter int unsigned IMEM_DEPTH = 11
) (
    input  logic         branch_taken,
    input  logic [31:0]  branch_target,
    input  fetch_state_e state,
    input  logic         stall,
    input  logic         fetch_valid,
    input  logic [31:0]  fetch_pc,
    input  logic [31:0]  pc,
    output logic [31:0]  read_address,
    output fetch_sel_e   sel,
    output logic [31:0]  issue_pc,
    output logic         issue_in_range
);

    always_comb begin
        read_address = word_idx(pc);
        sel          = SEL_HOLD;
        issue_pc     = pc;
        if (branch_taken) begin
            read_address = word_idx(branch_target);
            sel          = SEL_BRANCH;
            issue_pc     = branch_target & 32'hFFFF_FFFC;
        end else if (state == FETCH_HALT) begin
            // Park the memory on an in-range word while nothing is issued.
            read_address = 32'd0;
            sel          = SEL_HOLD;
        end else if (stall) begin
            read_address = fetch_valid ? word_idx(fetch_pc) : word_idx(pc);
            sel          = SEL_HOLD;
        end else begin
            read_address = word_idx(pc);
            sel          = SEL_SEQ;
        end
        issue_in_range = word_idx(issue_pc) < 32'(IMEM_DEPTH);
    end

endmodule

// File: rtl/fetch_unit.sv
// PC / fetch control ahead of a 1-cycle registered instruction memory; one instruction per cycle.
// Stall replays the current word, branches redirect with no bubble, running past IMEM_DEPTH halts.
module fetch_unit
    import riscv_fetch_pkg::*;
#(
    parameter logic [31:0]  RESET_PC   = DEFAULT_RESET_PC,
    parameter int unsigned  IMEM_DEPTH = 11
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic [31:0] readAddress,
    output logic [31:0] fetch_pc,
    output logic        fetch_valid,
    output logic [31:0] pc_plus4,
    output logic        halted
);

    fetch_state_e state;
    logic [31:0]  pc;
    fetch_sel_e   sel;
    logic [31:0]  issue_pc;
    logic         issue_in_range;

    fetch_addr_sel #(
        .IMEM_DEPTH(IMEM_DEPTH)
    ) u_addr_sel (
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .state         (state),
        .stall         (stall),
        .fetch_valid   (fetch_valid),
        .fetch_pc      (fetch_pc),
        .pc            (pc),
        .read_address  (readAddress),
        .sel           (sel),
        .issue_pc      (issue_pc),
        .issue_in_range(issue_in_range)
    );

    assign pc_plus4 = fetch_pc + 32'(INSTR_BYTES);

    always_ff @(posedge clock) begin
        if (!reset) begin
            pc          <= RESET_PC;
            fetch_pc    <= 32'd0;
            fetch_valid <= 1'b0;
            state       <= FETCH_RUN;
            halted      <= 1'b0;
        end else begin
            case (sel)
                SEL_SEQ, SEL_BRANCH: begin
                    if (issue_in_range) begin
                        fetch_pc    <= issue_pc;
                        fetch_valid <= 1'b1;
                        pc          <= issue_pc + 32'(INSTR_BYTES);
                        state       <= FETCH_RUN;
                        halted      <= 1'b0;
                    end else begin
                        // pc and fetch_pc keep their last values while halted.
                        fetch_valid <= 1'b0;
                        state       <= FETCH_HALT;
                        halted      <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized plus directed stimulus against a behavioural fetch model; monitor scoreboards each cycle.
module tb_fetch_unit;

    localparam int unsigned DEPTH = 11;

    logic        clock = 1'b0;
    logic        reset;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [31:0] readAddress;
    logic [31:0] fetch_pc;
    logic        fetch_valid;
    logic [31:0] pc_plus4;
    logic        halted;

    fetch_unit #(
        .RESET_PC  (32'h0000_0000),
        .IMEM_DEPTH(DEPTH)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .stall        (stall),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .readAddress  (readAddress),
        .fetch_pc     (fetch_pc),
        .fetch_valid  (fetch_valid),
        .pc_plus4     (pc_plus4),
        .halted       (halted)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] raddr;
        logic [31:0] fpc;
        logic        valid;
        logic        halt;
    } obs_t;

    obs_t queue_exp[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    bit   stim_done = 0;

    // Reference model: the architectural fetch state as the spec describes it.
    logic [31:0] m_pc, m_fpc;
    logic        m_valid, m_halt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [31:0] model_raddr(input logic br, input logic [31:0] bt, input logic st);
        if (br)                return bt / 4;
        if (m_halt)            return 32'd0;
        if (st && m_valid)     return m_fpc / 4;
        return m_pc / 4;
    endfunction

    task automatic model_edge(input logic rst, input logic st, input logic br, input logic [31:0] bt);
        logic [31:0] addr;
        if (!rst) begin
            m_pc = 32'd0; m_fpc = 32'd0; m_valid = 1'b0; m_halt = 1'b0;
        end else if (br || (!m_halt && !st)) begin
            addr = br ? (bt / 4) * 4 : m_pc;
            if (addr / 4 < DEPTH) begin
                m_fpc = addr; m_valid = 1'b1; m_pc = addr + 4; m_halt = 1'b0;
            end else begin
                m_valid = 1'b0; m_halt = 1'b1;
            end
        end
    endtask

    // Drive one cycle, record what the DUT must show this cycle, then advance the model.
    task automatic cycle(input logic rst, input logic st, input logic br, input logic [31:0] bt);
        obs_t o;
        reset = rst; stall = st; branch_taken = br; branch_target = bt;
        o.raddr = model_raddr(br, bt, st);
        o.fpc   = m_fpc;
        o.valid = m_valid;
        o.halt  = m_halt;
        queue_exp.push_back(o);
        model_edge(rst, st, br, bt);
        @(posedge clock);
        #1;
    endtask

    initial begin : monitor
        obs_t o;
        forever begin
            @(negedge clock);
            if (queue_exp.size() > 0) begin
                o = queue_exp.pop_front();
                check("readAddress", readAddress, o.raddr);
                check("fetch_pc", fetch_pc, o.fpc);
                check("fetch_valid", 32'(fetch_valid), 32'(o.valid));
                check("halted", 32'(halted), 32'(o.halt));
                if (o.valid) check("pc_plus4", pc_plus4, o.fpc + 4);
            end
        end
    end

    initial begin : stimulus
        logic [31:0] tgt;
        reset = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = 32'd0;
        @(posedge clock);
        #1;
        model_edge(1'b0, 1'b0, 1'b0, 32'd0);
        cycle(1'b0, 1'b0, 1'b0, 32'd0);
        // Sequential start, then a 3-cycle stall with fetch_pc = 8.
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, 32'd0);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b0, 32'd0);
        cycle(1'b1, 1'b0, 1'b0, 32'd0);
        cycle(1'b1, 1'b0, 1'b0, 32'd0);
        // fetch_pc = 16 here: redirect to unaligned 6 (word 1).
        cycle(1'b1, 1'b0, 1'b1, 32'h0000_0006);
        // Run off the end of memory and sit halted, stall included.
        for (int i = 0; i < 14; i++) cycle(1'b1, 1'b0, 1'b0, 32'd0);
        for (int i = 0; i < 5; i++) cycle(1'b1, i[0], 1'b0, 32'd0);
        cycle(1'b1, 1'b0, 1'b1, 32'd8);
        cycle(1'b1, 1'b0, 1'b0, 32'd0);
        for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, 1'b0, 32'd0);
        cycle(1'b1, 1'b0, 1'b1, 32'd48);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, 32'd0);
        // Reset during stall plus branch, then restart.
        cycle(1'b1, 1'b0, 1'b1, 32'd20);
        cycle(1'b1, 1'b1, 1'b0, 32'd0);
        cycle(1'b0, 1'b1, 1'b1, 32'd12);
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'b0, 32'd0);
        // Random traffic, including far targets that wrap the word compare.
        for (int i = 0; i < 800; i++) begin
            tgt = ($urandom_range(0, 15) == 0) ? ($urandom() | 32'h8000_0000)
                                               : 32'($urandom_range(0, 56));
            cycle(($urandom_range(0, 63) != 0),
                  ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 7) == 0),
                  tgt);
        end
        reset = 1'b1; stall = 1'b0; branch_taken = 1'b0;
        repeat (3) @(negedge clock);
        check("scoreboard_drained", 32'(queue_exp.size()), 32'd0);
        stim_done = 1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin : watchdog
        #200000;
        if (!stim_done) begin
            $display("FAIL watchdog: simulation exceeded time limit, got %0t expected < 200000", $time);
            $fatal(1);
        end
    end

endmodule
